// File: rtl/bram_fifo_ctrl_pkg.sv
// bram_fifo_ctrl_pkg
//   Shared sizing helpers for the BRAM-backed FIFO controller and its RAM.
//   Pointers and the occupancy counter carry one bit more than the RAM
//   address, so a completely full FIFO can be told apart from an empty one.
//   No ports; functions only.
package bram_fifo_ctrl_pkg;

    // Width of the read/write pointers and of COUNT.
    // This is the RAM address width plus the wrap bit.
    function automatic int cnt_width(input int ptr_width);
        return ptr_width + 1;
    endfunction

    // Number of words the RAM holds.
    function automatic int fifo_depth(input int ptr_width);
        return 1 << ptr_width;
    endfunction

endpackage

// File: rtl/simple_dp_bram.sv
// simple_dp_bram
//   Simple dual-port block RAM with one write port and one registered read port.
//   Contents are not reset.
//   DOUT updates only on an enabled read and holds its value between reads.
// Ports
//   CLK        in   clock, posedge
//   WR_PTR_EN  in   write-port enable (gates WR_EN)
//   WR_EN      in   write strobe
//   WR_PTR     in   write address, PTR_WIDTH bits
//   DIN        in   write data, DATA_WIDTH bits
//   RD_EN      in   read strobe
//   RD_PTR     in   read address, PTR_WIDTH bits
//   DOUT       out  registered read data, DATA_WIDTH bits
module simple_dp_bram
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 72,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  CLK,
    input  logic                  WR_PTR_EN,
    input  logic                  WR_EN,
    input  logic [PTR_WIDTH-1:0]  WR_PTR,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  RD_EN,
    input  logic [PTR_WIDTH-1:0]  RD_PTR,
    output logic [DATA_WIDTH-1:0] DOUT
);

    logic [DATA_WIDTH-1:0] mem [fifo_depth(PTR_WIDTH)];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge CLK) begin
        if (WR_PTR_EN && WR_EN) begin
            mem[WR_PTR] <= DIN;
        end
    end

    // No reset on the output register, so it maps onto the RAM's own
    // output latch.
    always_ff @(posedge CLK) begin
        if (RD_EN) begin
            rd_data_q <= mem[RD_PTR];
        end
    end

    assign DOUT = rd_data_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl
//   Synchronous FIFO built around one simple_dp_bram.
//   Owns the pointers, the occupancy count, the status flags and the
//   read-data valid strobe.
//   A pop sampled at a clock edge shows its word on DOUT, with DOUT_VALID
//   high, for the following cycle.
// Ports
//   CLK          in   clock, posedge
//   RESETN       in   asynchronous active-low reset
//   WR_EN, DIN   in   push request and data
//   RD_EN        in   pop request
//   DOUT         out  popped word (held between pops)
//   DOUT_VALID   out  one-cycle pulse per accepted pop
//   FULL         out  flag
//   ALMOST_FULL  out  flag
//   EMPTY        out  flag
//   COUNT        out  stored-word count
//   OVERFLOW     out  pulse for a refused push
//   UNDERFLOW    out  pulse for a refused pop
//   ALMOST_FULL_TH must lie in 1..2**PTR_WIDTH.
module bram_fifo_ctrl
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 72,
    parameter int PTR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH = 6
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  DOUT_VALID,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic                  EMPTY,
    output logic [PTR_WIDTH:0]    COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int CNT_WIDTH = cnt_width(PTR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] AF_TH = CNT_WIDTH'(ALMOST_FULL_TH);
    localparam logic [CNT_WIDTH-2:0] ZERO_PAD = '0;

    logic [CNT_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 almost_full_q, almost_full_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 wr_acc, rd_acc;

    // Acceptance is judged against the registered flags, so a push into a
    // full FIFO is refused even when a pop frees a slot at the same edge.
    // Flags are computed from the next-state pointers, so they line up with
    // COUNT in every cycle rather than lagging it by one.
    always_comb begin
        wr_acc        = WR_EN & ~full_q;
        rd_acc        = RD_EN & ~empty_q;
        wr_ptr_d      = wr_ptr_q + {ZERO_PAD, wr_acc};
        rd_ptr_d      = rd_ptr_q + {ZERO_PAD, rd_acc};
        count_d       = count_q + {ZERO_PAD, wr_acc} - {ZERO_PAD, rd_acc};
        empty_d       = (wr_ptr_d == rd_ptr_d);
        full_d        = (wr_ptr_d[PTR_WIDTH-1:0] == rd_ptr_d[PTR_WIDTH-1:0]) &&
                        (wr_ptr_d[PTR_WIDTH] != rd_ptr_d[PTR_WIDTH]);
        almost_full_d = (count_d >= AF_TH);
        dout_valid_d  = rd_acc;
        overflow_d    = WR_EN & full_q;
        underflow_d   = RD_EN & empty_q;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almost_full_q <= 1'b0;
            dout_valid_q  <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            almost_full_q <= almost_full_d;
            dout_valid_q  <= dout_valid_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    // The RAM read register supplies DOUT directly.
    // A refused pop leaves it untouched.
    simple_dp_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_ram (
        .CLK       (CLK),
        .WR_PTR_EN (1'b1),
        .WR_EN     (wr_acc),
        .WR_PTR    (wr_ptr_q[PTR_WIDTH-1:0]),
        .DIN       (DIN),
        .RD_EN     (rd_acc),
        .RD_PTR    (rd_ptr_q[PTR_WIDTH-1:0]),
        .DOUT      (DOUT)
    );

    assign DOUT_VALID  = dout_valid_q;
    assign FULL        = full_q;
    assign ALMOST_FULL = almost_full_q;
    assign EMPTY       = empty_q;
    assign COUNT       = count_q;
    assign OVERFLOW    = overflow_q;
    assign UNDERFLOW   = underflow_q;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl
//   Scenario-driven bench for bram_fifo_ctrl (72-bit words, depth 8, almost-full at 6).
//   A queue holds the words the FIFO should contain.
//   Each accepted pop moves the queue head into the expected read data.
module tb_bram_fifo_ctrl;

    localparam int DW    = 72;
    localparam int PW    = 3;
    localparam int AFT   = 6;
    localparam int DEPTH = 8;

    logic          CLK = 1'b0;
    logic          RESETN;
    logic          WR_EN;
    logic [DW-1:0] DIN;
    logic          RD_EN;
    logic [DW-1:0] DOUT;
    logic          DOUT_VALID;
    logic          FULL;
    logic          ALMOST_FULL;
    logic          EMPTY;
    logic [PW:0]   COUNT;
    logic          OVERFLOW;
    logic          UNDERFLOW;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [DW-1:0] sb[$];
    int            m_count = 0;
    logic          exp_valid;
    logic [DW-1:0] exp_dout;
    logic          exp_ovf;
    logic          exp_udf;

    bram_fifo_ctrl #(
        .DATA_WIDTH     (DW),
        .PTR_WIDTH      (PW),
        .ALMOST_FULL_TH (AFT)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .WR_EN       (WR_EN),
        .DIN         (DIN),
        .RD_EN       (RD_EN),
        .DOUT        (DOUT),
        .DOUT_VALID  (DOUT_VALID),
        .FULL        (FULL),
        .ALMOST_FULL (ALMOST_FULL),
        .EMPTY       (EMPTY),
        .COUNT       (COUNT),
        .OVERFLOW    (OVERFLOW),
        .UNDERFLOW   (UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    // Drives one cycle of requests and advances the reference model.
    // Outputs are left to settle 1 time unit past the edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        logic wa;
        logic ra;
        WR_EN = w;
        DIN   = d;
        RD_EN = r;
        wa = w && (m_count != DEPTH);
        ra = r && (m_count != 0);
        exp_ovf   = w && (m_count == DEPTH);
        exp_udf   = r && (m_count == 0);
        exp_valid = ra;
        if (ra) exp_dout = sb.pop_front();
        if (wa) sb.push_back(d);
        m_count = m_count + int'(wa) - int'(ra);
        @(posedge CLK);
        #1;
        WR_EN = 1'b0;
        RD_EN = 1'b0;
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        WR_EN  = 1'b0;
        RD_EN  = 1'b0;
        DIN    = '0;
        @(posedge CLK);
        #1;
        total++;
        if (EMPTY !== 1'b1 || COUNT !== 4'd0) begin
            bad++;
            $display("[TB] FAIL reset_empty: EMPTY=%b COUNT=%0d, required EMPTY=1 COUNT=0", EMPTY, COUNT);
        end
        total++;
        if ({FULL, ALMOST_FULL, DOUT_VALID, OVERFLOW, UNDERFLOW} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: F/AF/DV/OVF/UDF=%b, required 00000",
                     {FULL, ALMOST_FULL, DOUT_VALID, OVERFLOW, UNDERFLOW});
        end
        RESETN = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0);
            total++;
            if (COUNT !== 4'(i) || ALMOST_FULL !== (i >= 6) || FULL !== (i == 8) || EMPTY !== 1'b0) begin
                bad++;
                $display("[TB] FAIL fill_%0d: COUNT=%0d AF=%b FULL=%b EMPTY=%b, required COUNT=%0d AF=%b FULL=%b EMPTY=0",
                         i, COUNT, ALMOST_FULL, FULL, EMPTY, i, (i >= 6), (i == 8));
            end
        end
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            total++;
            if (DOUT_VALID !== 1'b1 || DOUT !== DW'(i) || DOUT !== exp_dout) begin
                bad++;
                $display("[TB] FAIL drain_%0d: DV=%b DOUT=%h, required DV=1 DOUT=%h", i, DOUT_VALID, DOUT, DW'(i));
            end
            total++;
            if (COUNT !== 4'(DEPTH - i) || EMPTY !== (i == DEPTH)) begin
                bad++;
                $display("[TB] FAIL drain_cnt_%0d: COUNT=%0d EMPTY=%b, required COUNT=%0d EMPTY=%b",
                         i, COUNT, EMPTY, DEPTH - i, (i == DEPTH));
            end
        end
        step(1'b0, '0, 1'b0);
        total++;
        if (DOUT_VALID !== 1'b0 || DOUT !== DW'(8)) begin
            bad++;
            $display("[TB] FAIL drain_hold: DV=%b DOUT=%h, required DV=0 DOUT=8", DOUT_VALID, DOUT);
        end
    endtask

    task automatic test_overflow_underflow();
        step(1'b0, '0, 1'b1);
        total++;
        if (UNDERFLOW !== 1'b1 || exp_udf !== 1'b1 || DOUT_VALID !== 1'b0 || COUNT !== 4'd0) begin
            bad++;
            $display("[TB] FAIL underflow: UDF=%b DV=%b COUNT=%0d, required UDF=1 DV=0 COUNT=0",
                     UNDERFLOW, DOUT_VALID, COUNT);
        end
        step(1'b0, '0, 1'b0);
        total++;
        if (UNDERFLOW !== 1'b0) begin
            bad++;
            $display("[TB] FAIL underflow_pulse: UDF=%b, required 0", UNDERFLOW);
        end
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(8'hA0 + i), 1'b0);
        step(1'b1, DW'(8'h99), 1'b0);
        total++;
        if (OVERFLOW !== 1'b1 || exp_ovf !== 1'b1 || COUNT !== 4'd8 || FULL !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overflow: OVF=%b COUNT=%0d FULL=%b, required OVF=1 COUNT=8 FULL=1",
                     OVERFLOW, COUNT, FULL);
        end
        step(1'b0, '0, 1'b0);
        total++;
        if (OVERFLOW !== 1'b0 || COUNT !== 4'd8) begin
            bad++;
            $display("[TB] FAIL overflow_pulse: OVF=%b COUNT=%0d, required OVF=0 COUNT=8", OVERFLOW, COUNT);
        end
    endtask

    // Expects to start with the FIFO full of 0xA0..0xA7.
    task automatic test_simultaneous();
        step(1'b1, DW'(8'h77), 1'b1);
        total++;
        if (DOUT_VALID !== 1'b1 || DOUT !== DW'(8'hA0) || COUNT !== 4'd7 ||
            OVERFLOW !== 1'b1 || FULL !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sim_full: DV=%b DOUT=%h COUNT=%0d OVF=%b FULL=%b, required 1 a0 7 1 0",
                     DOUT_VALID, DOUT, COUNT, OVERFLOW, FULL);
        end
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            total++;
            if (DOUT_VALID !== 1'b1 || DOUT !== exp_dout) begin
                bad++;
                $display("[TB] FAIL sim_drain_%0d: DV=%b DOUT=%h, required DV=1 DOUT=%h",
                         i, DOUT_VALID, DOUT, exp_dout);
            end
        end
        step(1'b1, DW'(8'h55), 1'b1);
        total++;
        if (COUNT !== 4'd1 || UNDERFLOW !== 1'b1 || DOUT_VALID !== 1'b0 || EMPTY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sim_empty: COUNT=%0d UDF=%b DV=%b EMPTY=%b, required 1 1 0 0",
                     COUNT, UNDERFLOW, DOUT_VALID, EMPTY);
        end
        step(1'b0, '0, 1'b1);
        total++;
        if (DOUT_VALID !== 1'b1 || DOUT !== DW'(8'h55) || EMPTY !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sim_empty_pop: DV=%b DOUT=%h EMPTY=%b, required DV=1 DOUT=55 EMPTY=1",
                     DOUT_VALID, DOUT, EMPTY);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(i), 1'b0);
            total++;
            if (COUNT !== 4'd1 || EMPTY !== 1'b0) begin
                bad++;
                $display("[TB] FAIL wrap_push_%0d: COUNT=%0d EMPTY=%b, required COUNT=1 EMPTY=0", i, COUNT, EMPTY);
            end
            step(1'b0, '0, 1'b1);
            total++;
            if (DOUT_VALID !== 1'b1 || DOUT !== DW'(i) || COUNT !== 4'd0) begin
                bad++;
                $display("[TB] FAIL wrap_pop_%0d: DV=%b DOUT=%h COUNT=%0d, required DV=1 DOUT=%h COUNT=0",
                         i, DOUT_VALID, DOUT, COUNT, DW'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) step(1'b1, {8'hBB, 64'(i)}, 1'b0);
        total++;
        if (COUNT !== 4'd4) begin
            bad++;
            $display("[TB] FAIL stream_prefill: COUNT=%0d, required 4", COUNT);
        end
        for (int i = 4; i < 20; i++) begin
            step(1'b1, {8'hBB, 64'(i)}, 1'b1);
            total++;
            if (DOUT_VALID !== 1'b1 || DOUT !== exp_dout || DOUT !== {8'hBB, 64'(i - 4)} || COUNT !== 4'd4) begin
                bad++;
                $display("[TB] FAIL stream_%0d: DV=%b DOUT=%h COUNT=%0d, required DV=1 DOUT=%h COUNT=4",
                         i, DOUT_VALID, DOUT, COUNT, {8'hBB, 64'(i - 4)});
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1);
            total++;
            if (DOUT_VALID !== 1'b1 || DOUT !== exp_dout) begin
                bad++;
                $display("[TB] FAIL stream_drain_%0d: DV=%b DOUT=%h, required DV=1 DOUT=%h",
                         i, DOUT_VALID, DOUT, exp_dout);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h31 + i), 1'b0);
        step(1'b1, DW'(8'h36), 1'b1);
        total++;
        if (COUNT !== 4'd5 || DOUT_VALID !== 1'b1 || DOUT !== DW'(8'h31)) begin
            bad++;
            $display("[TB] FAIL mid_pre: COUNT=%0d DV=%b DOUT=%h, required COUNT=5 DV=1 DOUT=31",
                     COUNT, DOUT_VALID, DOUT);
        end
        #2;
        RESETN = 1'b0;
        #1;
        total++;
        if (EMPTY !== 1'b1 || COUNT !== 4'd0 || DOUT_VALID !== 1'b0 || FULL !== 1'b0 || ALMOST_FULL !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset: EMPTY=%b COUNT=%0d DV=%b FULL=%b AF=%b, required 1 0 0 0 0",
                     EMPTY, COUNT, DOUT_VALID, FULL, ALMOST_FULL);
        end
        sb.delete();
        m_count = 0;
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
        step(1'b1, DW'(8'hC3), 1'b0);
        step(1'b0, '0, 1'b1);
        total++;
        if (DOUT_VALID !== 1'b1 || DOUT !== DW'(8'hC3) || COUNT !== 4'd0 || EMPTY !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_after: DV=%b DOUT=%h COUNT=%0d EMPTY=%b, required DV=1 DOUT=c3 COUNT=0 EMPTY=1",
                     DOUT_VALID, DOUT, COUNT, EMPTY);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run still active at %0t, required completion before 100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
